// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory subsystem: arbiter state encoding,
// the default data-port streak limit and a small saturating-counter helper.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Back-to-back data grants tolerated while a fetch is waiting (legal 1..15)
  localparam int unsigned MAX_DM_STREAK_DEFAULT = 4;

  // Width of the streak counter; fixes the upper bound of MAX_DM_STREAK
  localparam int unsigned STREAK_W = 4;

  // Increment that sticks at the limit instead of wrapping
  function automatic logic [STREAK_W-1:0] satInc(input logic [STREAK_W-1:0] value,
                                                 input logic [STREAK_W-1:0] limit);
    return (value < limit) ? value + 1'b1 : limit;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single unified
// memory. Data accesses normally win, but a pending fetch is guaranteed a
// slot after MAX_DM_STREAK consecutive data grants so the pipeline front end
// cannot starve. One access is outstanding at a time; every access ends with
// a one-cycle DONE state carrying the served port's ready pulse.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = MAX_DM_STREAK_DEFAULT,
  parameter int unsigned ADDR_W        = 30
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,

  output logic              stall_f,
  output logic              stall_m,
  output logic              proto_err
);

  localparam logic [STREAK_W-1:0] C_MAX_STREAK = STREAK_W'(MAX_DM_STREAK);

  arb_state_t          r_state;
  logic [STREAK_W-1:0] r_streak;
  logic                r_memReq;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [31:0]         r_memWdata;
  logic [31:0]         r_ifRdata;
  logic [31:0]         r_dmRdata;
  logic                r_ifReady;
  logic                r_dmReady;
  logic                r_protoErr;

  logic                w_fetchStarved;
  logic                w_grantDm;
  logic                w_grantIf;

  // Grant selector: data wins unless the fetch has already waited out a full streak
  always_comb begin
    w_fetchStarved = if_req && (r_streak == C_MAX_STREAK);
    w_grantDm      = dm_req && !w_fetchStarved;
    w_grantIf      = !w_grantDm && if_req;
  end

  // Arbiter FSM; every memory-side and requester-side output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_streak   <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_ifRdata  <= '0;
      r_dmRdata  <= '0;
      r_ifReady  <= 1'b0;
      r_dmReady  <= 1'b0;
      r_protoErr <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // An ack here belongs to no access (e.g. one abandoned by reset)
          if (mem_ack) begin
            r_protoErr <= 1'b1;
          end
          if (w_grantDm) begin
            r_state    <= DM_WAIT;
            r_memReq   <= 1'b1;
            r_memWe    <= dm_we;
            r_memAddr  <= dm_addr;
            r_memWdata <= dm_wdata;
            r_streak   <= if_req ? satInc(r_streak, C_MAX_STREAK) : '0;
          end else if (w_grantIf) begin
            r_state    <= IF_WAIT;
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b0;
            r_memAddr  <= if_addr;
            r_memWdata <= '0;
            r_streak   <= '0;
          end
        end
        IF_WAIT: begin
          if (mem_ack) begin
            r_ifRdata <= mem_rdata;
            r_memReq  <= 1'b0;
            r_ifReady <= 1'b1;
            r_state   <= DONE;
          end
        end
        DM_WAIT: begin
          if (mem_ack) begin
            // Stores leave the previous load data visible
            if (!r_memWe) begin
              r_dmRdata <= mem_rdata;
            end
            r_memReq  <= 1'b0;
            r_dmReady <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (mem_ack) begin
            r_protoErr <= 1'b1;
          end
          r_ifReady <= 1'b0;
          r_dmReady <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign if_rdata  = r_ifRdata;
  assign if_ready  = r_ifReady;
  assign dm_rdata  = r_dmRdata;
  assign dm_ready  = r_dmReady;
  assign proto_err = r_protoErr;

  // Requesters freeze while their access is outstanding
  assign stall_f = if_req & ~r_ifReady;
  assign stall_m = dm_req & ~r_dmReady;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DM_STREAK, default 4: consecutive data-port grants allowed while a fetch is pending; legal range 1..15.
REQ-002 Parameter ADDR_W, default 30: word-address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 if_req  in  1  fetch request; held high until if_ready.
REQ-006 if_addr  in  ADDR_W  fetch word address.
REQ-007 if_rdata  out  32  fetched instruction; valid when if_ready.
REQ-008 if_ready  out  1  one-cycle fetch-complete pulse.
REQ-009 dm_req  in  1  data request; held high until dm_ready.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr  in  ADDR_W  data word address.
REQ-012 dm_wdata  in  32  store data.
REQ-013 dm_rdata  out  32  load data; valid when dm_ready.
REQ-014 dm_ready  out  1  one-cycle data-complete pulse.
REQ-015 mem_req  out  1  request to unified memory.
REQ-016 mem_we  out  1  write strobe to memory.
REQ-017 mem_addr  out  ADDR_W  memory word address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_rdata  in  32  memory read data; valid with mem_ack.
REQ-020 mem_ack  in  1  memory completion, one cycle.
REQ-021 stall_f  out  1  combinational: if_req & ~if_ready.
REQ-022 stall_m  out  1  combinational: dm_req & ~dm_ready.
REQ-023 proto_err  out  1  sticky: mem_ack received with no access outstanding.

Function
REQ-024 FSM states: IDLE, IF_WAIT, DM_WAIT, DONE.
REQ-025 IDLE: if dm_req and not (if_req and streak == MAX_DM_STREAK) -> DM_WAIT; else if if_req -> IF_WAIT; else stay.
REQ-026 Grant edge: mem_addr, mem_we, mem_wdata register the selected port's inputs; mem_req = 1 from the next cycle.
REQ-027 IF grant: mem_we = 0, mem_wdata = 0.
REQ-028 mem_req, mem_addr, mem_we and mem_wdata are held stable in IF_WAIT/DM_WAIT until the mem_ack cycle, inclusive.
REQ-029 mem_ack in IF_WAIT/DM_WAIT: mem_rdata is captured into if_rdata (IF_WAIT) or dm_rdata (DM_WAIT, loads only); mem_req -> 0; state -> DONE.
REQ-030 DONE: the served port's ready = 1 for exactly this cycle; no new grant; next state IDLE.
REQ-031 Store completion: dm_ready pulses; dm_rdata keeps its previous value.
REQ-032 Latency: request in IDLE at cycle 0 with mem_ack on its first mem_req cycle gives ready at cycle 2; N memory wait cycles give ready at cycle 2+N.
REQ-033 streak (4 bits): +1 on a DM grant while if_req = 1; cleared on any IF grant; cleared on a DM grant while if_req = 0; saturates at MAX_DM_STREAK.
REQ-034 mem_ack in IDLE or DONE sets proto_err; no other state change.
REQ-035 proto_err clears only on reset.
REQ-036 A requester dropping req mid-access does not abort it; the access completes and the ready pulse is still issued.

Reset
REQ-037 rst_n low, immediately and asynchronously: state = IDLE, streak = 0, and every output = 0 (including if_rdata and dm_rdata).
REQ-038 Reset mid-access abandons the access; a late mem_ack after release, arriving in IDLE, sets proto_err.

Structure
REQ-039 The state enum and MAX_DM_STREAK default live in the shared package mips_pkg.
REQ-040 Single flat module; the only sub-logic is the combinational grant selector, kept inline; no sub-module.

Verification
REQ-041 Fetch-only: if_req = 1, if_addr = 0x10, mem_ack on the first mem_req cycle, mem_rdata = 0x8C020004 -> if_ready at cycle 2 with if_rdata = 0x8C020004; stall_f = 1 on cycles 0-1.
REQ-042 Simultaneous: if_req = dm_req = 1, dm_we = 1, dm_addr = 0x20, dm_wdata = 0xDEADBEEF -> first memory access is a write to 0x20 with 0xDEADBEEF; the fetch is granted only after dm_ready and DONE.
REQ-043 Starvation: dm_req re-asserted continuously with if_req = 1, MAX_DM_STREAK = 4 -> 4 DM grants, then 1 IF grant, then DM resumes.
REQ-044 Wait states: load from 0x40 with mem_ack delayed 5 cycles -> mem_req and mem_addr stable for 6 cycles; dm_ready at cycle 7; dm_rdata = mem_rdata from the ack cycle.
REQ-045 Reset in DM_WAIT: mem_req falls asynchronously with rst_n; a mem_ack after release sets proto_err = 1, which stays 1 until the next reset.
